// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//
// Purpose:
//   Shared definitions for the data-memory responder: RV32 load/store funct3
//   encodings, the responder FSM state type and a helper that classifies a
//   funct3 as illegal for a given access direction.
//
// Contents:
//   F3_B / F3_H / F3_W    - signed byte / half / word (also SB/SH/SW)
//   F3_BU / F3_HU         - zero-extended byte / half loads
//   mem_state_t           - IDLE, WAIT, RESP
//   funct3_illegal()      - 1 when funct3 is not a legal load/store encoding
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Stores only have signed-looking encodings (SB/SH/SW); the unsigned load
  // encodings are meaningless for a store and are rejected.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    if (f3 == F3_B || f3 == F3_H || f3 == F3_W) begin
      bad = 1'b0;
    end else if (!we && (f3 == F3_BU || f3 == F3_HU)) begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//
// Purpose:
//   Purely combinational byte-lane steering for RV32 loads and stores.
//   Produces the byte enables and lane-positioned store word for a write,
//   the selected and extended load value for a read, and an alignment flag.
//
// Ports:
//   funct3     in  [2:0]  RV32 load/store size/sign encoding
//   addr_lo    in  [1:0]  low byte-address bits (lane select)
//   wdata      in  [31:0] right-aligned store data
//   rword      in  [31:0] full word currently held at the addressed index
//   byte_en    out [3:0]  lanes to write (0 for an unknown size)
//   wword      out [31:0] store data replicated into every candidate lane
//   rdata_ext  out [31:0] selected byte/half/word, sign or zero extended
//   misalign   out        half on odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rword[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Store data is replicated across the word so that the byte enables alone
  // decide which lanes change; no shifter is needed.
  always_comb begin
    byte_en  = 4'b0000;
    wword    = 32'h0000_0000;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign = addr_lo[0];
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
      end
      2'b10: begin
        misalign = (addr_lo != 2'b00);
        byte_en  = 4'b1111;
        wword    = wdata;
      end
      default: begin
        byte_en  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_W:    rdata_ext = rword;
      F3_BU:   rdata_ext = {24'h00_0000, sel_byte};
      F3_HU:   rdata_ext = {16'h0000, sel_half};
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Multi-cycle data memory for the CPU load/store port. One request is taken
//   over a valid/ready handshake, held for LATENCY wait cycles, performed once
//   against the word array, and the response is held until the consumer takes
//   it. Only one transaction is ever outstanding.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two, at least 2
//   LATENCY      wait cycles between acceptance and response, 0..15
//
// Ports:
//   clk         in       rising-edge clock
//   reset       in       asynchronous reset, active low
//   req_valid   in       request present
//   req_ready   out      request can be accepted this cycle (IDLE)
//   req_we      in       1 = store, 0 = load
//   req_funct3  in [2:0] RV32 load/store funct3
//   req_addr    in [31:0] byte address
//   req_wdata   in [31:0] right-aligned store data
//   rsp_valid   out      response present (RESP)
//   rsp_ready   in       consumer takes the response
//   rsp_rdata   out [31:0] extended load data; 0 for stores and errors
//   rsp_err     out      misaligned, illegal funct3 or out-of-range access
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_CAP  = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit          SKIP_WAIT = (LATENCY == 0);

  mem_state_t  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_we;
  logic [2:0]    acc_funct3;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_rword;
  logic [3:0]    byte_en;
  logic [31:0]   wword;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic          out_of_range;
  logic          illegal;
  logic          acc_err;
  logic          do_access;
  logic          mem_write;

  // With LATENCY=0 the access happens on the acceptance edge itself, before
  // the request registers are loaded, so the live request must be used there.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we     = req_we;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_rword = mem[acc_idx];

  mem_lane_align u_lane_align (
    .funct3    (acc_funct3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (acc_rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  // The 33-bit compare keeps the capacity test exact even if the array ever
  // spans the full 32-bit address space.
  always_comb begin
    out_of_range = ({1'b0, acc_addr} >= BYTE_CAP);
    illegal      = funct3_illegal(acc_we, acc_funct3);
    acc_err      = out_of_range | illegal | misalign;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (SKIP_WAIT) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            count_d = LAT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (count_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0000_0000 : rdata_ext;
    end
  end

  // Qualifying with reset keeps a LATENCY=0 store presented during reset from
  // writing on an edge where the FSM is held in IDLE.
  assign mem_write = do_access && acc_we && !acc_err && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately not reset; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives the responder with directed and random load/store traffic and
// compares every response against a byte-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;
  localparam int MAX_WAIT    = 64;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [MEM_BYTES];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Reference behaviour: the access size in bytes, its signedness and legality
  // come straight from the RV32 encoding; memory is a flat byte array.
  function automatic void model_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int   nbytes;
    bit   sgn;
    bit   legal;
    logic [31:0] v;
    nbytes = 4;
    sgn    = 1'b0;
    legal  = 1'b1;
    rd     = 32'h0;
    er     = 1'b0;
    case (f3)
      3'b000: begin nbytes = 1; sgn = 1'b1; end
      3'b001: begin nbytes = 2; sgn = 1'b1; end
      3'b010: begin nbytes = 4; end
      3'b100: begin nbytes = 1; legal = !we; end
      3'b101: begin nbytes = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    if (!legal || addr >= 32'(MEM_BYTES) ||
        (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00)) begin
      er = 1'b1;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[addr + i];
      if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rd = v;
    end
  endfunction

  // Issues one request starting on a falling edge, waits for the response
  // with a bounded cycle budget and takes it. edges counts rising edges from
  // the acceptance edge up to the one that raised rsp_valid.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int edges);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && edges < MAX_WAIT) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  // Every word gets a known random value so later loads are fully predictable.
  task automatic test_fill();
    logic [31:0] wd, rd, mrd;
    logic er, mer;
    int edges, bad;
    bad = 0;
    for (int w = 0; w < DEPTH_WORDS; w++) begin
      wd = $urandom;
      run_txn(1'b1, LW, 32'(w * 4), wd, rd, er, edges);
      model_access(1'b1, LW, 32'(w * 4), wd, mrd, mer);
      if (er !== mer || rd !== mrd || edges != LATENCY + 1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL fill_stores: got %0d bad responses expected 0", bad); end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        known;
    logic [31:0] exp_rd;
    logic        exp_er;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [15];
    logic [31:0] rd, mrd, exp_rd;
    logic er, mer, exp_er;
    int edges;
    tbl = '{
      '{1'b1, LW,     32'h10,  32'h12345678, 1'b1, 32'h00000000, 1'b0},
      '{1'b0, LW,     32'h10,  32'h0,        1'b1, 32'h12345678, 1'b0},
      '{1'b1, LB,     32'h11,  32'h000000AB, 1'b1, 32'h00000000, 1'b0},
      '{1'b0, LW,     32'h10,  32'h0,        1'b1, 32'h1234AB78, 1'b0},
      '{1'b0, LB,     32'h11,  32'h0,        1'b1, 32'hFFFFFFAB, 1'b0},
      '{1'b0, LBU,    32'h11,  32'h0,        1'b1, 32'h000000AB, 1'b0},
      '{1'b1, LH,     32'h22,  32'h00008001, 1'b1, 32'h00000000, 1'b0},
      '{1'b0, LH,     32'h22,  32'h0,        1'b1, 32'hFFFF8001, 1'b0},
      '{1'b0, LHU,    32'h22,  32'h0,        1'b1, 32'h00008001, 1'b0},
      '{1'b0, LW,     32'h20,  32'h0,        1'b0, 32'h0,        1'b0},
      '{1'b0, LW,     32'h13,  32'h0,        1'b1, 32'h00000000, 1'b1},
      '{1'b1, LH,     32'h15,  32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1},
      '{1'b0, LW,     32'h14,  32'h0,        1'b0, 32'h0,        1'b0},
      '{1'b0, LW,     32'h400, 32'h0,        1'b1, 32'h00000000, 1'b1},
      '{1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h00000000, 1'b1}
    };
    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, edges);
      model_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, mrd, mer);
      exp_rd = tbl[i].known ? tbl[i].exp_rd : mrd;
      exp_er = tbl[i].known ? tbl[i].exp_er : mer;
      checks++;
      if (rd !== exp_rd) begin errors++; $display("[TB] FAIL directed_%0d_rdata: got %h expected %h", i, rd, exp_rd); end
      checks++;
      if (er !== exp_er) begin errors++; $display("[TB] FAIL directed_%0d_err: got %b expected %b", i, er, exp_er); end
      checks++;
      if (edges != LATENCY + 1) begin errors++; $display("[TB] FAIL directed_%0d_latency: got %0d edges expected %0d", i, edges, LATENCY + 1); end
      if (i == 9) begin
        checks++;
        if (rd[31:16] !== 16'h8001) begin errors++; $display("[TB] FAIL directed_lw20_upper: got %h expected 8001", rd[31:16]); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  legal_f3 [5];
    logic [31:0] addr, wd, rd, mrd;
    logic [2:0]  f3;
    logic we, er, mer;
    int edges;
    legal_f3 = '{LB, LH, LW, LBU, LHU};
    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
      wd   = $urandom;
      run_txn(we, f3, addr, wd, rd, er, edges);
      model_access(we, f3, addr, wd, mrd, mer);
      checks++;
      if (rd !== mrd) begin errors++; $display("[TB] FAIL random_%0d_rdata: we=%b f3=%b addr=%h got %h expected %h", n, we, f3, addr, rd, mrd); end
      checks++;
      if (er !== mer) begin errors++; $display("[TB] FAIL random_%0d_err: we=%b f3=%b addr=%h got %b expected %b", n, we, f3, addr, er, mer); end
      checks++;
      if (edges != LATENCY + 1) begin errors++; $display("[TB] FAIL random_%0d_latency: got %0d edges expected %0d", n, edges, LATENCY + 1); end
    end
  endtask

  // A load immediately after a store to the same place must see the new data.
  task automatic test_back_to_back();
    logic [2:0]  st_f3, ld_f3;
    logic [31:0] addr, wd, rd, mrd;
    logic er, mer;
    int edges, sz;
    for (int n = 0; n < 20; n++) begin
      sz    = $urandom_range(0, 2);
      st_f3 = 3'(sz);
      ld_f3 = (sz < 2 && $urandom_range(0, 1) == 1) ? (st_f3 | 3'b100) : st_f3;
      addr  = 32'($urandom_range(0, MEM_BYTES - 1));
      addr  = addr & ~((32'd1 << sz) - 32'd1);
      wd    = $urandom;
      run_txn(1'b1, st_f3, addr, wd, rd, er, edges);
      model_access(1'b1, st_f3, addr, wd, mrd, mer);
      run_txn(1'b0, ld_f3, addr, 32'h0, rd, er, edges);
      model_access(1'b0, ld_f3, addr, 32'h0, mrd, mer);
      checks++;
      if (rd !== mrd || er !== mer) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: addr=%h f3=%b got %h/%b expected %h/%b", n, addr, ld_f3, rd, er, mrd, mer);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addr, mrd;
    logic mer;
    int waited;
    addr = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
    model_access(1'b0, LW, addr, 32'h0, mrd, mer);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = LW;
    req_addr   = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_response_timeout: got valid=%b expected 1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== mrd || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b ready=%b expected 1 %h 0 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, mrd);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  // Reset lands while the store is still waiting; the store must never land.
  task automatic test_reset_mid_store();
    logic [31:0] rd, mrd;
    logic er, mer;
    int edges;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = LW;
    req_addr   = 32'h30;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_in_wait: got ready=%b valid=%b expected 0 0", req_ready, rsp_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_after_release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    end
    run_txn(1'b0, LW, 32'h30, 32'h0, rd, er, edges);
    model_access(1'b0, LW, 32'h30, 32'h0, mrd, mer);
    checks++;
    if (rd !== mrd || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_aborted_store: got %h/%b expected %h/0", rd, er, mrd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion expected finish before 1000000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
